// File: rtl/rf_pkg.sv
// Shared definitions for the register file and the pipeline stages around it.
//   RF_N      : default data width in bits
//   RF_A_W    : default address width (depth = 2**RF_A_W)
//   rf_data_t : data word type used by decode and writeback
//   rf_addr_t : register address type used by decode and writeback
package rf_pkg;
    localparam int RF_N   = 32;
    localparam int RF_A_W = 5;

    typedef logic [RF_N-1:0]   rf_data_t;
    typedef logic [RF_A_W-1:0] rf_addr_t;
endpackage

// File: rtl/reg_cell.sv
// One N-bit storage entry of the register file.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high clear
//   load : capture d on the next rising edge
//   d    : data in
//   q    : stored value
module reg_cell #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Multi-port register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero entry 0 and optional write-to-read bypass.
//   clk                : rising-edge clock
//   rst                : asynchronous active-high reset, clears every entry
//   ena                : global enable; a write needs ena and wr_ena
//   wr_ena             : write request
//   wr_addr, wr_data   : write port
//   rd_addr0, rd_data0 : read port 0 (combinational)
//   rd_addr1, rd_data1 : read port 1 (combinational)
// There is no FSM; the only state is the entries themselves.
module register_file
    import rf_pkg::*;
#(
    parameter int N        = RF_N,
    parameter int A_W      = RF_A_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic           wr_ena,
    input  logic [A_W-1:0] wr_addr,
    input  logic [N-1:0]   wr_data,
    input  logic [A_W-1:0] rd_addr0,
    output logic [N-1:0]   rd_data0,
    input  logic [A_W-1:0] rd_addr1,
    output logic [N-1:0]   rd_data1
);

    localparam int DEPTH = 1 << A_W;

    logic [DEPTH-1:0][N-1:0] entries;
    logic                    wr_commit;
    logic                    wr_is_zero;

    // !rst keeps the bypass path quiet while the array is held in reset.
    assign wr_is_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_commit  = ena && wr_ena && !rst && !wr_is_zero;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_entry
            if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
                assign entries[i] = '0;
            end else begin : g_cell
                reg_cell #(.N(N)) u_cell (
                    .clk  (clk),
                    .rst  (rst),
                    .load (wr_commit && (wr_addr == A_W'(i))),
                    .d    (wr_data),
                    .q    (entries[i])
                );
            end
        end
    endgenerate

    // Priority: zero entry over bypass over stored contents.
    always_comb begin
        rd_data0 = entries[rd_addr0];
        if ((BYPASS != 0) && wr_commit && (wr_addr == rd_addr0)) begin
            rd_data0 = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr0 == '0)) begin
            rd_data0 = '0;
        end
    end

    always_comb begin
        rd_data1 = entries[rd_addr1];
        if ((BYPASS != 0) && wr_commit && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
    end

endmodule
